// File: rtl/sketch_hash_bank.sv
// sketch_hash_bank
// Multi-row hash front end for the count-min sketch datapath. Each accepted
// key is folded into ROWS bucket indices. Mode 0 gives the legacy XOR-fold in
// every row; mode 1 rotates the key per row, XORs a row seed, then applies a
// shift-XOR mix in the second stage. Two register stages with a combinational
// ready chain, so a full pipe still streams one beat per cycle.
module sketch_hash_bank #(
  parameter int                       KEY_W    = 104,
  parameter int                       HASH_W   = 10,
  parameter int                       ROWS     = 4,
  parameter int                       ROT_STEP = 7,
  parameter logic [ROWS*HASH_W-1:0]   SEEDS    = {10'h2A5, 10'h15A, 10'h0F3, 10'h000},
  parameter int                       TAG_W    = 16
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [KEY_W-1:0]         in_key,
  input  logic                     in_mode,
  input  logic [TAG_W-1:0]         in_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ROWS*HASH_W-1:0]   out_hash,
  output logic [TAG_W-1:0]         out_tag,
  output logic [31:0]              hash_count
);

  // Fold geometry: FULL whole chunks, then a partial chunk of REM bits that
  // is left-aligned inside its HASH_W-bit slot (PAD_W zeros below it).
  localparam int NCH    = (KEY_W + HASH_W - 1) / HASH_W;
  localparam int FULL   = KEY_W / HASH_W;
  localparam int FULL_W = FULL * HASH_W;
  localparam int EXT_W  = NCH * HASH_W;
  localparam int PAD_W  = EXT_W - KEY_W;
  localparam int HALF   = HASH_W / 2;

  // XOR-fold of a key into HASH_W bits. The key is first spread into an
  // NCH*HASH_W vector with the top partial chunk shifted up by PAD_W, so the
  // fold itself is a plain XOR over equal-width chunks. Works for REM == 0 too.
  function automatic logic [HASH_W-1:0] fold(input logic [KEY_W-1:0] x);
    logic [EXT_W-1:0]  ext;
    logic [HASH_W-1:0] acc;
    ext = '0;
    ext[FULL_W-1:0] = x[FULL_W-1:0];
    for (int b = FULL_W; b < KEY_W; b++) begin
      ext[b + PAD_W] = x[b];
    end
    acc = '0;
    for (int c = 0; c < NCH; c++) begin
      acc = acc ^ ext[c*HASH_W +: HASH_W];
    end
    return acc;
  endfunction

  // Handshake chain: a stage may load when it is empty or the stage after it
  // is moving. in_ready is purely combinational from out_ready and the valids.
  logic adv1;
  logic adv2;

  // Stage 1 state
  logic                          s1_valid_reg;
  logic                          s1_mode_reg;
  logic [TAG_W-1:0]              s1_tag_reg;
  logic [ROWS-1:0][HASH_W-1:0]   s1_hash_reg;
  logic [ROWS-1:0][HASH_W-1:0]   s1_hash_next;

  // Stage 2 state (drives the outputs directly)
  logic                          s2_valid_reg;
  logic [TAG_W-1:0]              s2_tag_reg;
  logic [ROWS-1:0][HASH_W-1:0]   s2_hash_reg;
  logic [ROWS-1:0][HASH_W-1:0]   s2_hash_next;

  logic [31:0]                   count_reg;
  logic [31:0]                   count_next;

  assign adv2     = !s2_valid_reg || out_ready;
  assign adv1     = !s1_valid_reg || adv2;
  assign in_ready = adv1;

  // Per-row stage-1 hash: rotation amount is a per-row constant, so each row
  // is just a rewiring of the key followed by its own fold.
  genvar gi;
  generate
    for (gi = 0; gi < ROWS; gi++) begin : g_row
      localparam int SH = (gi * ROT_STEP) % KEY_W;
      logic [KEY_W-1:0] rot_key;

      if (SH == 0) begin : g_norot
        assign rot_key = in_key;
      end else begin : g_rot
        assign rot_key = {in_key[KEY_W-1-SH:0], in_key[KEY_W-1:KEY_W-SH]};
      end

      assign s1_hash_next[gi] = in_mode ? (fold(rot_key) ^ SEEDS[gi*HASH_W +: HASH_W])
                                        : fold(in_key);

      // Stage-2 mix: fold the high half back onto the low bits (mode 1 only).
      assign s2_hash_next[gi] = s1_mode_reg ? (s1_hash_reg[gi] ^ (s1_hash_reg[gi] >> HALF))
                                            : s1_hash_reg[gi];
    end
  endgenerate

  // Saturating handshake counter: stops at all-ones rather than wrapping.
  assign count_next = (count_reg == 32'hFFFF_FFFF) ? count_reg : count_reg + 32'd1;

  // Stage 1 valid: follows in_valid whenever the stage is allowed to move.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_reg <= 1'b0;
    end else if (adv1) begin
      s1_valid_reg <= in_valid;
    end
  end

  // Stage 1 payload: captured only for a real beat so idle cycles keep it quiet.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1_mode_reg <= 1'b0;
      s1_tag_reg  <= '0;
      s1_hash_reg <= '0;
    end else if (adv1 && in_valid) begin
      s1_mode_reg <= in_mode;
      s1_tag_reg  <= in_tag;
      s1_hash_reg <= s1_hash_next;
    end
  end

  // Stage 2 valid: the output valid; holds while downstream stalls.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s2_valid_reg <= 1'b0;
    end else if (adv2) begin
      s2_valid_reg <= s1_valid_reg;
    end
  end

  // Stage 2 payload: the output data; stable for as long as out_valid is held.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s2_tag_reg  <= '0;
      s2_hash_reg <= '0;
    end else if (adv2 && s1_valid_reg) begin
      s2_tag_reg  <= s1_tag_reg;
      s2_hash_reg <= s2_hash_next;
    end
  end

  // Count every completed output handshake.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_reg <= '0;
    end else if (s2_valid_reg && out_ready) begin
      count_reg <= count_next;
    end
  end

  assign out_valid  = s2_valid_reg;
  assign out_hash   = s2_hash_reg;
  assign out_tag    = s2_tag_reg;
  assign hash_count = count_reg;

endmodule

// File: tb/tb_sketch_hash_bank.sv
// Testbench for sketch_hash_bank: directed beats with hand-computed literal
// expectations, plus a bit-level reference model and scoreboard checked on
// every cycle the outputs are meaningful.
module tb_sketch_hash_bank;
  localparam int KEY_W    = 104;
  localparam int HASH_W   = 10;
  localparam int ROWS     = 4;
  localparam int ROT_STEP = 7;
  localparam int TAG_W    = 16;
  localparam int HW       = ROWS * HASH_W;

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [KEY_W-1:0]  in_key = '0;
  logic              in_mode = 1'b0;
  logic [TAG_W-1:0]  in_tag = '0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [HW-1:0]     out_hash;
  logic [TAG_W-1:0]  out_tag;
  logic [31:0]       hash_count;

  sketch_hash_bank dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_key     (in_key),
    .in_mode    (in_mode),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_hash   (out_hash),
    .out_tag    (out_tag),
    .hash_count (hash_count)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [HW-1:0]    hash;
    logic [TAG_W-1:0] tag;
  } exp_t;

  exp_t           sb[$];
  int             model_count = 0;
  int             cyc = 0;
  int             last_hs_cyc = -10;
  int             run_len = 0;
  int             in_total = 0;
  int             out_total = 0;
  bit             hold_valid = 1'b0;
  logic [HW-1:0]  hold_hash;
  logic [TAG_W-1:0] hold_tag;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [HASH_W-1:0] seed_of(input int r);
    case (r)
      0:       return 10'h000;
      1:       return 10'h0F3;
      2:       return 10'h15A;
      default: return 10'h2A5;
    endcase
  endfunction

  // Reference: scatter each key bit to its rotated position, then to the bit
  // of the bucket index it lands on, and XOR it in.
  function automatic logic [HASH_W-1:0] model_row(input logic [KEY_W-1:0] key, input bit mode, input int r);
    logic [KEY_W-1:0]  k;
    logic [HASH_W-1:0] h;
    int s;
    int pos;
    int full_w;
    full_w = (KEY_W / HASH_W) * HASH_W;
    s = mode ? (r * ROT_STEP) % KEY_W : 0;
    k = '0;
    for (int b = 0; b < KEY_W; b++) k[(b + s) % KEY_W] = key[b];
    h = '0;
    for (int b = 0; b < KEY_W; b++) begin
      if (k[b]) begin
        if (b < full_w) pos = b % HASH_W;
        else pos = b - full_w + (HASH_W - KEY_W % HASH_W);
        h[pos] = ~h[pos];
      end
    end
    if (mode) begin
      h = h ^ seed_of(r);
      h = h ^ (h >> (HASH_W / 2));
    end
    return h;
  endfunction

  function automatic logic [HW-1:0] model_hash(input logic [KEY_W-1:0] key, input bit mode);
    logic [HW-1:0] res;
    res = '0;
    for (int r = 0; r < ROWS; r++) res[r*HASH_W +: HASH_W] = model_row(key, mode, r);
    return res;
  endfunction

  function automatic logic [KEY_W-1:0] rand_key();
    logic [KEY_W-1:0] k;
    k = '0;
    for (int i = 0; i < 4; i++) k = {k[KEY_W-33:0], $urandom()};
    return k;
  endfunction

  // Compare process: scoreboard, counter and stall-stability checks each cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      cyc++;
      if (reset_n) begin
        check("hash_count", 64'(hash_count), 64'(model_count));
        if (hold_valid) begin
          check("hold_valid", 64'(out_valid), 64'(1));
          check("hold_hash", 64'(out_hash), 64'(hold_hash));
          check("hold_tag", 64'(out_tag), 64'(hold_tag));
        end
        hold_valid = 1'b0;
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            check("unexpected_out", 64'(out_valid), 64'(0));
          end else begin
            e = sb.pop_front();
            check("sb_hash", 64'(out_hash), 64'(e.hash));
            check("sb_tag", 64'(out_tag), 64'(e.tag));
          end
          out_total++;
          model_count++;
          run_len = (last_hs_cyc == cyc - 1) ? run_len + 1 : 1;
          last_hs_cyc = cyc;
        end else if (out_valid) begin
          hold_valid = 1'b1;
          hold_hash  = out_hash;
          hold_tag   = out_tag;
        end
        if (in_valid && in_ready) begin
          sb.push_back({model_hash(in_key, in_mode), in_tag});
          in_total++;
        end
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Present one beat from posedge+1 and hold it until it is taken.
  task automatic send(input logic [KEY_W-1:0] key, input bit mode, input logic [TAG_W-1:0] tag);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_key   = key;
    in_mode  = mode;
    in_tag   = tag;
    @(negedge clock);
    while (!in_ready && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (!in_ready) check("send_timeout", 64'(in_ready), 64'(1));
    step();
    in_valid = 1'b0;
  endtask

  // Wait for the scoreboard to empty; ends at posedge+1.
  task automatic drain();
    int n;
    n = 0;
    @(negedge clock);
    while ((sb.size() != 0 || out_valid) && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (sb.size() != 0) check("drain_timeout", 64'(sb.size()), 64'(0));
    step();
  endtask

  initial begin
    logic [KEY_W-1:0] k;
    int acc;

    // Reset state
    repeat (2) @(negedge clock);
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_out_hash", 64'(out_hash), 64'(0));
    check("rst_out_tag", 64'(out_tag), 64'(0));
    check("rst_hash_count", 64'(hash_count), 64'(0));
    step();
    reset_n = 1'b1;
    @(negedge clock);
    check("in_ready_after_reset", 64'(in_ready), 64'(1));

    // Pin the model with hand-computed values
    k = 104'h3FF;
    check("model_m0_3ff", 64'(model_hash(k, 1'b0)), 64'({4{10'h3FF}}));
    check("model_m1_row0", 64'(model_row(k, 1'b1, 0)), 64'(10'h3E0));
    k = 104'h1;
    check("model_m1_row1", 64'(model_row(k, 1'b1, 1)), 64'(10'h070));
    k = 104'hF;
    k = k << 100;
    check("model_m0_top", 64'(model_hash(k, 1'b0)), 64'({4{10'h3C0}}));
    step();

    // 1: mode 0, low chunk all ones; 2-cycle latency
    send(104'h3FF, 1'b0, 16'hA001);
    @(negedge clock);
    check("t1_latency_stage1", 64'(out_valid), 64'(0));
    @(negedge clock);
    check("t1_out_valid", 64'(out_valid), 64'(1));
    check("t1_hash", 64'(out_hash), 64'({4{10'h3FF}}));
    check("t1_tag", 64'(out_tag), 64'(16'hA001));
    step();

    // 2: mode 0, partial top chunk left-aligned
    k = 104'hF;
    k = k << 100;
    send(k, 1'b0, 16'hA002);
    @(negedge clock);
    @(negedge clock);
    check("t2_hash", 64'(out_hash), 64'({4{10'h3C0}}));
    check("t2_tag", 64'(out_tag), 64'(16'hA002));
    step();

    // 3: mode 1 rows
    send(104'h3FF, 1'b1, 16'hA003);
    @(negedge clock);
    @(negedge clock);
    check("t3_row0", 64'(out_hash[9:0]), 64'(10'h3E0));
    step();
    send(104'h1, 1'b1, 16'hA004);
    @(negedge clock);
    @(negedge clock);
    check("t3_row1", 64'(out_hash[19:10]), 64'(10'h070));
    step();
    drain();

    // 4: ten back-to-back beats
    for (int i = 0; i < 10; i++) send(rand_key(), i[0], 16'h4000 + 16'(i));
    drain();
    check("t4_run_len", 64'(run_len), 64'(10));
    check("t4_hash_count", 64'(hash_count), 64'(14));

    // 5: downstream stall while streaming
    out_ready = 1'b0;
    acc = 0;
    in_valid = 1'b1;
    in_key = rand_key();
    in_mode = 1'b1;
    in_tag = 16'h5000;
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      if (in_ready) acc++;
      step();
      if (in_key !== '0 && acc > 0 && in_tag == 16'h5000 + 16'(acc - 1)) begin
        in_key = rand_key();
        in_mode = ~in_mode;
        in_tag = 16'h5000 + 16'(acc);
      end
    end
    @(negedge clock);
    check("t5_accepts", 64'(acc), 64'(2));
    check("t5_in_ready", 64'(in_ready), 64'(0));
    check("t5_out_valid", 64'(out_valid), 64'(1));
    step();
    out_ready = 1'b1;
    for (int c = 0; c < 50 && acc < 6; c++) begin
      @(negedge clock);
      if (in_ready) acc++;
      step();
      if (in_tag == 16'h5000 + 16'(acc - 1)) begin
        in_key = rand_key();
        in_mode = ~in_mode;
        in_tag = 16'h5000 + 16'(acc);
      end
    end
    in_valid = 1'b0;
    drain();
    check("t5_no_loss", 64'(out_total), 64'(in_total));
    check("t5_hash_count", 64'(hash_count), 64'(20));

    // 6: reset with two beats in flight
    out_ready = 1'b0;
    send(rand_key(), 1'b1, 16'h6001);
    send(rand_key(), 1'b0, 16'h6002);
    #1;
    reset_n = 1'b0;
    sb.delete();
    model_count = 0;
    hold_valid = 1'b0;
    #1;
    check("t6_async_drop", 64'(out_valid), 64'(0));
    repeat (2) @(negedge clock);
    check("t6_rst_count", 64'(hash_count), 64'(0));
    check("t6_rst_hash", 64'(out_hash), 64'(0));
    step();
    reset_n = 1'b1;
    out_ready = 1'b1;
    repeat (4) @(negedge clock);
    check("t6_no_stale", 64'(out_valid), 64'(0));
    check("t6_count_after", 64'(hash_count), 64'(0));
    step();
    send(104'h3FF, 1'b1, 16'h6003);
    drain();
    check("t6_count_one", 64'(hash_count), 64'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
